prog_readback: RTL and testbench
================================

# prog_readback

Program-memory readback engine: on a start pulse, reads a byte range of the instruction RAM as 32-bit words and streams each byte out over a dedicated 8N1 UART transmit line. It is the reverse path of the UART programmer, letting the host verify a downloaded image. It sits beside the programmer, sharing the instruction-RAM read port while the core is held in programming mode.

## Interface
- MEM_SIZE, 32767: instruction memory size in bytes; INSTRW = $clog2(MEM_SIZE).
- BAUD_CYCLE, 868: clk cycles per UART bit.
- LSB_FIRST, 1'b1: data-bit order within a frame.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- baseAddr  in  INSTRW  first byte address, latched on start; bits [1:0] ignored (word aligned).
- byteCount  in  INSTRW+1  number of bytes to send, latched on start.
- memRdEn  out  1  read strobe to instruction RAM.
- memAddr  out  INSTRW  word-aligned byte address to instruction RAM.
- memRdData  in  32  RAM read data, valid one cycle after memRdEn.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, SEND, DONE.
- IDLE: start=1 and byteCount≠0 → latch addrReg=baseAddr&~3, remReg=byteCount → RD_REQ. start=1 and byteCount=0 → DONE directly (no frame sent). start while not in IDLE is ignored.
- RD_REQ: memRdEn=1, memAddr=addrReg → RD_WAIT.
- RD_WAIT: capture memRdData into wordReg, byteIdx=0 → SEND.
- SEND: hand byte wordReg[8*byteIdx+:8] to serializer (little-endian: byte 0 first). On serializer frame-done: remReg−1; if remReg becomes 0 → DONE; else if byteIdx=3 → addrReg+=4 (wraps modulo 2^INSTRW), → RD_REQ; else byteIdx+1, stay SEND.
- DONE: done=1 for one cycle → IDLE.
- Partial last word (byteCount not multiple of 4): only remaining bytes sent; rest of word discarded.
- Frame: start bit 0, 8 data bits (order per LSB_FIRST), stop bit 1; each bit exactly BAUD_CYCLE clocks.
- rst at any time: state→IDLE, transfer abandoned, serializer cleared, tx=1 from next edge.
- Reset values: tx=1, busy=0, done=0, memRdEn=0, memAddr=0.

## Timing
- Start accepted at edge N: RD_REQ in cycle N+1, RD_WAIT N+2, tx start bit begins at cycle N+3.
- Consecutive bytes within a word: next start bit immediately follows stop bit (zero idle).
- Word boundary: 2 idle cycles (tx=1) between stop bit and next start bit.
- Last stop bit ends at cycle M: done pulses in cycle M+1; busy high from N+1 through M+1 inclusive.
- memRdEn high exactly one cycle per word; memAddr stable only when memRdEn=1 (0 otherwise).
- Total duration for k bytes, w words: 10·k·BAUD_CYCLE + 2·w + 1 cycles after start.

## Structure
- Shared package: state enum (IDLE, RD_REQ, RD_WAIT, SEND, DONE) and UART framing constants (FRAME_BITS=10, START_BIT=0, STOP_BIT=1), reusable by the rx/echo transmitters.
- Sub-module uart_tx_byte: load/data in, frameDone pulse out, tx out; contains baud counter and bit counter. Top holds FSM, address/remaining counters, word register.

## Test plan
- baseAddr=0, byteCount=4, RAM word 0 = 32'h44332211, BAUD_CYCLE=4 → frames 0x11,0x22,0x33,0x44 back-to-back; first start bit at N+3; one memRdEn; one done pulse.
- byteCount=6, words 0/4 = 32'hA3A2A1A0/32'hB3B2B1B0 → A0,A1,A2,A3,B0,B1; 2 idle cycles before B0; memAddr sequence 0,4.
- byteCount=0 → no memRdEn, tx stays 1, done one cycle after start.
- baseAddr=2^INSTRW−4, byteCount=8 → second read at memAddr=0 (wrap).
- start pulses during SEND → ignored; byte stream and done count unchanged.
- rst asserted mid-data-bit of byte 2 → next cycle tx=1, busy=0, done=0; fresh start afterwards behaves as test 1.

Source files
------------

// File: rtl/prog_readback_pkg.sv
// Shared definitions for the program-memory readback path: FSM encodings,
// 8N1 framing constants and a bit-order helper reused by the other UART transmitters.
package prog_readback_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_WAIT = 3'd2;
  localparam state_t ST_SEND    = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/prog_readback_uart_tx.sv
// 8N1 byte serializer. A load on the frame's last cycle chains the next
// frame with no idle gap; frameDone_o flags that last cycle.
module uart_tx_byte
  import prog_readback_pkg::*;
#(
  parameter int   BAUD_CYCLE = 868,
  parameter logic LSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       frameDone_o,
  output logic       tx_o
);

  localparam int             BW        = (BAUD_CYCLE > 1) ? $clog2(BAUD_CYCLE) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_CYCLE - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(FRAME_BITS - 1);

  logic          active_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          bitEnd;

  assign bitEnd      = active_q && (baud_q == BAUD_LAST);
  assign frameDone_o = bitEnd && (bit_q == BIT_LAST);
  assign tx_o        = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= STOP_BIT;
    end else if (load_i) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= START_BIT;
    end else if (frameDone_o) begin
      active_q <= 1'b0;
      tx_q     <= STOP_BIT;
    end else if (bitEnd) begin
      baud_q <= '0;
      bit_q  <= bit_q + 4'd1;
      // bit_q counts the bit just finished: after data bit 7 comes the stop bit
      tx_q   <= (bit_q == BIT_LAST - 4'd1) ? STOP_BIT : shift_q[0];
    end else if (active_q) begin
      baud_q <= baud_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load_i)      shift_q <= LSB_FIRST ? data_i : bit_reverse8(data_i);
    else if (bitEnd) shift_q <= {1'b0, shift_q[7:1]};
  end

endmodule

// File: rtl/prog_readback.sv
// Instruction-RAM readback engine: fetches 32-bit words from a byte range and
// streams their bytes little-endian over an 8N1 transmit line.
module prog_readback
  import prog_readback_pkg::*;
#(
  parameter int   MEM_SIZE   = 32767,
  parameter int   BAUD_CYCLE = 868,
  parameter logic LSB_FIRST  = 1'b1,
  localparam int  INSTRW     = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INSTRW-1:0] baseAddr,
  input  logic [INSTRW:0]   byteCount,
  output logic              memRdEn,
  output logic [INSTRW-1:0] memAddr,
  input  logic [31:0]       memRdData,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [INSTRW-1:0] addr_q, addr_d;
  logic [INSTRW:0]   rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              load;
  logic [7:0]        loadByte;
  logic              frameDone;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    word_d   = word_q;
    idx_d    = idx_q;
    load     = 1'b0;
    loadByte = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (byteCount != '0) begin
            addr_d  = baseAddr & ~INSTRW'(3);
            rem_d   = byteCount;
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // byte 0 goes straight from the RAM bus so its start bit lands next cycle
        word_d   = memRdData;
        idx_d    = 2'd0;
        load     = 1'b1;
        loadByte = memRdData[7:0];
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (frameDone) begin
          rem_d = rem_q - (INSTRW+1)'(1);
          if (rem_q == (INSTRW+1)'(1)) begin
            state_d = ST_DONE;
          end else if (idx_q == 2'd3) begin
            addr_d  = addr_q + INSTRW'(4);
            state_d = ST_RD_REQ;
          end else begin
            idx_d    = idx_q + 2'd1;
            load     = 1'b1;
            loadByte = word_q[{idx_d, 3'b000} +: 8];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    rem_q  <= rem_d;
    word_q <= word_d;
    idx_q  <= idx_d;
  end

  assign memRdEn = (state_q == ST_RD_REQ);
  assign memAddr = memRdEn ? addr_q : '0;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  uart_tx_byte #(
    .BAUD_CYCLE (BAUD_CYCLE),
    .LSB_FIRST  (LSB_FIRST)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .data_i      (loadByte),
    .frameDone_o (frameDone),
    .tx_o        (tx)
  );

endmodule

// File: tb/tb_prog_readback.sv
// Directed bench for prog_readback: table of transfers checked cycle by cycle
// against an expected tx waveform, plus reset-state and mid-frame reset sequences.
module tb_prog_readback;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] baseAddr;
  logic [15:0] byteCount;
  logic        memRdEn;
  logic [14:0] memAddr;
  logic [31:0] memRdData;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:8191];

  typedef struct {
    logic [14:0] base;
    logic [15:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;     // expected bytes, first transmitted byte in [63:56]
    int          nwords;
    logic [14:0] a0;
    logic [14:0] a1;
    int          spur;    // sample index of an ignored start pulse, 0 = none
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) memRdData <= memRdEn ? mem[memAddr[14:2]] : 32'hx;

  prog_readback #(
    .MEM_SIZE   (32767),
    .BAUD_CYCLE (B),
    .LSB_FIRST  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .baseAddr  (baseAddr),
    .byteCount (byteCount),
    .memRdEn   (memRdEn),
    .memAddr   (memAddr),
    .memRdData (memRdData),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    logic [12:0] wi;
    wi = v.base[14:2];
    mem[wi] = v.w0;
    wi = wi + 13'd1;
    mem[wi] = v.w1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit          expq[$];
    logic [14:0] rdaddr[$];
    logic [7:0]  by;
    int L, txbad, txfirst, txact, txexp, donecnt, donepos, busybad, addridle;
    if (v.cnt != 0) begin
      expq.push_back(1'b1);
      expq.push_back(1'b1);
      for (int i = 0; i < int'(v.cnt); i++) begin
        if (i > 0 && i % 4 == 0) begin
          expq.push_back(1'b1);
          expq.push_back(1'b1);
        end
        by = v.exp[63-8*i -: 8];
        for (int c = 0; c < B; c++) expq.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < B; c++) expq.push_back(by[b]);
        for (int c = 0; c < B; c++) expq.push_back(1'b1);
      end
    end
    L = expq.size();
    load_mem(v);
    txbad = 0; txfirst = 0; txact = 0; txexp = 0;
    donecnt = 0; donepos = 0; busybad = 0; addridle = 0;

    @(negedge clk);
    start     = 1'b1;
    baseAddr  = v.base;
    byteCount = v.cnt;
    @(negedge clk);
    start = 1'b0;
    for (int s = 1; s <= L + 4; s++) begin
      if (s == v.spur) begin
        start     = 1'b1;
        baseAddr  = 15'h0200;
        byteCount = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (tx !== ((s <= L) ? expq[s-1] : 1'b1)) begin
        if (txbad == 0) begin
          txfirst = s;
          txact   = int'(tx);
          txexp   = (s <= L) ? int'(expq[s-1]) : 1;
        end
        txbad++;
      end
      if (done === 1'b1) begin
        donecnt++;
        donepos = s;
      end else if (done !== 1'b0) begin
        donecnt += 100;
      end
      if (busy !== (s <= L + 1)) busybad++;
      if (memRdEn === 1'b1) rdaddr.push_back(memAddr);
      else if (memAddr !== 15'h0) addridle++;
      @(negedge clk);
    end
    start = 1'b0;

    if (txbad != 0)
      $display("FAIL v%0d tx_wave: first bad sample %0d got %0d, expected %0d (%0d bad samples)",
               id, txfirst, txact, txexp, txbad);
    n_checks++;
    if (txbad != 0) n_fail++;
    chk($sformatf("v%0d done_count", id), donecnt, 1);
    chk($sformatf("v%0d done_pos", id), donepos, L + 1);
    chk($sformatf("v%0d busy_bad_cycles", id), busybad, 0);
    chk($sformatf("v%0d rd_count", id), rdaddr.size(), v.nwords);
    chk($sformatf("v%0d addr_when_idle", id), addridle, 0);
    if (v.nwords > 0 && rdaddr.size() > 0) chk($sformatf("v%0d addr0", id), rdaddr[0], v.a0);
    if (v.nwords > 1 && rdaddr.size() > 1) chk($sformatf("v%0d addr1", id), rdaddr[1], v.a1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{base:15'h0000, cnt:16'd4, w0:32'h44332211, w1:32'h0,
                exp:{8'h11, 8'h22, 8'h33, 8'h44, 32'h0}, nwords:1, a0:15'h0000, a1:15'h0, spur:0};
    vecs[1] = '{base:15'h0000, cnt:16'd6, w0:32'hA3A2A1A0, w1:32'hB3B2B1B0,
                exp:{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 16'h0}, nwords:2,
                a0:15'h0000, a1:15'h0004, spur:163};
    vecs[2] = '{base:15'h0010, cnt:16'd0, w0:32'h0, w1:32'h0,
                exp:64'h0, nwords:0, a0:15'h0, a1:15'h0, spur:0};
    vecs[3] = '{base:15'h7FFC, cnt:16'd8, w0:32'hDDCCBBAA, w1:32'h87654321,
                exp:{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21, 8'h43, 8'h65, 8'h87}, nwords:2,
                a0:15'h7FFC, a1:15'h0000, spur:0};
    vecs[4] = '{base:15'h0006, cnt:16'd3, w0:32'h0F0E0D0C, w1:32'h0,
                exp:{8'h0C, 8'h0D, 8'h0E, 40'h0}, nwords:1, a0:15'h0004, a1:15'h0, spur:0};
    vecs[5] = '{base:15'h0040, cnt:16'd5, w0:32'h04030201, w1:32'h000000F5,
                exp:{8'h01, 8'h02, 8'h03, 8'h04, 8'hF5, 24'h0}, nwords:2,
                a0:15'h0040, a1:15'h0044, spur:20};

    rst = 1'b1; start = 1'b0; baseAddr = '0; byteCount = '0;
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset memRdEn", memRdEn, 0);
    chk("reset memAddr", memAddr, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // reset during data bit 2 of byte 2 (0x33 -> that bit is 0)
    load_mem(vecs[0]);
    @(negedge clk);
    start = 1'b1; baseAddr = 15'h0000; byteCount = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (95) @(negedge clk);
    chk("midrst tx_before", tx, 0);
    chk("midrst busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", tx, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst memRdEn", memRdEn, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst tx_idle", tx, 1);
    run_vec(6, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
